mem_bus_if: RTL and testbench
=============================

# mem_bus_if

MEM-stage memory bus interface: the responder to the memory request carried out of the EX/MEM pipeline register (`mem_memrw`, `mem_memaddr`, `mem_memdata`). It turns each request into one word transaction on a req/ack data bus. While the transaction is pending it stalls the pipeline. It returns load data to the MEM stage for writeback.

## Interface
Parameters:
- `ADDR_W`, 32: width of `mem_memaddr`/`bus_addr`.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: maximum cycles to wait for `bus_ack`. Used only when `MEM_BUS_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `mem_memrw`  in  2  request type: 00 idle, 01 read, 10 write, 11 reserved (treated as idle).
- `mem_memaddr`  in  ADDR_W  byte address of the request.
- `mem_memdata`  in  DATA_W  store data.
- `stall_req`  out  1  hold the pipeline (combinational).
- `load_data`  out  DATA_W  last completed read data (registered).
- `addr_err`  out  1  one-cycle pulse on a misaligned request.
- `bus_req`  out  1  transaction request (registered).
- `bus_we`  out  1  1 = write (registered).
- `bus_addr`  out  ADDR_W  registered copy of the request address.
- `bus_wdata`  out  DATA_W  registered copy of the store data.
- `bus_ack`  in  1  bus completion; one-cycle pulse.
- `bus_rdata`  in  DATA_W  read data; valid when `bus_ack`=1.
- `bus_err`  out  1  timeout pulse. Driven 0 when `MEM_BUS_TIMEOUT_EN` is undefined.

## Operation
- The FSM has three states: IDLE, WAIT, DONE. The reset state is IDLE.
- **IDLE**
  - A request is valid when `mem_memrw` is 01 or 10.
  - Valid and `mem_memaddr[1:0]`==0:
    - Latch addr, wdata, and `bus_we` (=`mem_memrw[1]`).
    - Set `bus_req`=1.
    - Go to WAIT.
  - Valid and `mem_memaddr[1:0]`!=0:
    - No bus access.
    - `addr_err`=1 for the next cycle.
    - Stay in IDLE.
  - Not valid: stay in IDLE.
- **WAIT**
  - `bus_req` is held at 1 and bus outputs are frozen.
  - On `bus_ack`=1:
    - Clear `bus_req`.
    - On a read, capture `bus_rdata` into `load_data`.
    - Go to DONE.
- **DONE**
  - Lasts one cycle. `stall_req`=0, so the pipeline advances.
  - The request on the inputs is still the old one, so it is ignored.
  - Always go to IDLE.
- `stall_req` = (IDLE and valid and aligned) or WAIT.
  - Misaligned requests and idle cycles do not stall.
- `load_data` holds its value until the next read completes. Writes do not change it.
- `bus_ack` outside WAIT is ignored.
- Reset values of all outputs:
  - `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0.
  - `load_data`=0, `addr_err`=0, `bus_err`=0.
  - `stall_req`=0 while reset is held.

## Timing
- Request visible in cycle 0 (IDLE): `stall_req`=1 combinationally in cycle 0.
- `bus_req`, `bus_addr`, `bus_we`, `bus_wdata` are valid from cycle 1.
- Ack in cycle k (k≥1): `load_data` is updated and the state is DONE in cycle k+1, with `stall_req`=0 and `bus_req`=0.
- Minimum occupancy is 3 cycles per access (ack in cycle 1).
- Back-to-back requests: the next request is sampled in the IDLE cycle after DONE. There is no bubble beyond DONE.
- `rst` asserted mid-transaction: `bus_req` drops immediately (asynchronously) and the FSM returns to IDLE. A late `bus_ack` after reset is ignored.

## Configuration
- `MEM_BUS_TIMEOUT_EN` defined:
  - An 8+ bit counter runs in WAIT.
  - If `TIMEOUT` cycles elapse with no ack:
    - Clear `bus_req`.
    - `bus_err`=1 for one cycle.
    - On a read, load `load_data`=32'hDEADBEEF.
    - Go to DONE.
  - An ack in the same cycle as the expiry wins; it is a normal completion.
- `MEM_BUS_TIMEOUT_EN` undefined:
  - WAIT waits indefinitely.
  - `bus_err` is tied to 0.
  - The counter is not present.

## Test plan
- Read, ack after 2 cycles:
  - memrw=01, addr=0x100, `bus_rdata`=0x12345678.
  - Expect `stall_req`=1 for cycles 0–2 and `bus_req`=1 for cycles 1–2.
  - Expect `load_data`=0x12345678 and `stall_req`=0 in cycle 3.
- Write, ack in cycle 1:
  - memrw=10, addr=0x200, data=0xCAFEF00D.
  - Expect `bus_we`=1, `bus_addr`=0x200, `bus_wdata`=0xCAFEF00D in cycle 1.
  - Expect DONE in cycle 2 and `load_data` unchanged.
- Misaligned read, addr=0x102:
  - Expect `addr_err` pulse in cycle 1, `bus_req` never asserted, `stall_req`=0.
- Back-to-back read then write:
  - Expect two distinct bus transactions.
  - Expect no reissue of the first request during DONE.
- Reset mid-WAIT:
  - Assert `rst` in cycle 2 of a read.
  - Expect `bus_req`=0 immediately and all outputs at reset values.
  - Expect a stray ack after reset to be ignored.
- With `MEM_BUS_TIMEOUT_EN` defined and `TIMEOUT`=4:
  - Read with no ack.
  - Expect `bus_err` pulse, `load_data`=0xDEADBEEF, `stall_req`=0 in the following cycle.

Source files
------------

// File: rtl/mem_bus_if.sv
// MEM-stage responder: turns each EX/MEM memory request into one word transaction on a req/ack bus.
// Optional ack watchdog is compiled in with `define MEM_BUS_TIMEOUT_EN.
module mem_bus_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_memrw,
  input  logic [ADDR_W-1:0] mem_memaddr,
  input  logic [DATA_W-1:0] mem_memdata,
  output logic              stall_req,
  output logic [DATA_W-1:0] load_data,
  output logic              addr_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic              addr_err_q, addr_err_d;
  logic              valid, aligned, expire;

  assign valid   = (mem_memrw == 2'b01) || (mem_memrw == 2'b10);
  assign aligned = (mem_memaddr[1:0] == 2'b00);

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bus_err_q, bus_err_d;

  assign expire = (cnt_q == CntW'(TIMEOUT - 1));

  // Counter restarts every time WAIT is entered; an ack in the expiry cycle takes priority.
  always_comb begin
    cnt_d     = '0;
    bus_err_d = 1'b0;
    if (state_q == WAIT) begin
      cnt_d     = cnt_q + 1'b1;
      bus_err_d = !bus_ack && expire;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign expire  = 1'b0;
  // Without the watchdog this is low for any legal TIMEOUT.
  assign bus_err = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d    = state_q;
    bus_req_d  = bus_req_q;
    bus_we_d   = bus_we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    load_d     = load_q;
    addr_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid && aligned) begin
          bus_req_d = 1'b1;
          bus_we_d  = mem_memrw[1];
          addr_d    = mem_memaddr;
          wdata_d   = mem_memdata;
          state_d   = WAIT;
        end else if (valid) begin
          addr_err_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) load_d = bus_rdata;
          state_d = DONE;
        end else if (expire) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) load_d = DATA_W'(32'hDEADBEEF);
          state_d = DONE;
        end
      end
      // The inputs still hold the request just served, so DONE never samples them.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bus_req_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      load_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bus_req_q  <= bus_req_d;
      bus_we_q   <= bus_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      load_q     <= load_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign stall_req = !rst && (((state_q == IDLE) && valid && aligned) || (state_q == WAIT));
  assign load_data = load_q;
  assign addr_err  = addr_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Bench for mem_bus_if: transaction-level timing model, per-cycle compare, directed and random accesses.
// Define MEM_BUS_TIMEOUT_EN for both files to also exercise the ack watchdog.
module tb_mem_bus_if;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    memrw;
  logic [AW-1:0] memaddr;
  logic [DW-1:0] memdata;
  logic          busAck;
  logic [DW-1:0] busRdata;
  logic          stallReq, addrErr, busReq, busWe, busErr;
  logic [DW-1:0] loadData, busWdata;
  logic [AW-1:0] busAddr;

  mem_bus_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_memrw(memrw), .mem_memaddr(memaddr), .mem_memdata(memdata),
    .stall_req(stallReq), .load_data(loadData), .addr_err(addrErr),
    .bus_req(busReq), .bus_we(busWe), .bus_addr(busAddr), .bus_wdata(busWdata),
    .bus_ack(busAck), .bus_rdata(busRdata), .bus_err(busErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  logic          expStall, expBusReq, expAddrErr, expBusErr;
  logic          modelWe;
  logic [AW-1:0] modelAddr;
  logic [DW-1:0] modelWdata, modelLoad;
  bit            carryErr;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every output against the model once per cycle, away from the rising edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("stall_req", stallReq, expStall);
      checkOutput("bus_req", busReq, expBusReq);
      checkOutput("addr_err", addrErr, expAddrErr);
      checkOutput("bus_err", busErr, expBusErr);
      checkOutput("bus_we", busWe, modelWe);
      checkOutput("bus_addr", busAddr, modelAddr);
      checkOutput("bus_wdata", busWdata, modelWdata);
      checkOutput("load_data", loadData, modelLoad);
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setExp(input logic stall, input logic req, input logic aErr, input logic bErr);
    expStall   = stall;
    expBusReq  = req;
    expAddrErr = aErr;
    expBusErr  = bErr;
  endtask

  // One request presented in cycle 0; ackCycle k>=1 acks in cycle k, 0 never acks (watchdog expiry).
  task automatic applyStimulus(input logic [1:0] rw, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input int ackCycle,
                               input logic [DW-1:0] rdata);
    bit valid, go, prevCarry;
    int waitCycles;
    valid     = (rw == 2'b01) || (rw == 2'b10);
    go        = valid && (addr[1:0] == 2'b00);
    prevCarry = carryErr;
    carryErr  = valid && !go;
    memrw     = rw;
    memaddr   = addr;
    memdata   = data;
    busAck    = 1'($urandom_range(0, 1));
    busRdata  = $urandom;
    setExp(go, 1'b0, prevCarry, 1'b0);
    nextCycle();
    if (go) begin
      modelWe    = rw[1];
      modelAddr  = addr;
      modelWdata = data;
      waitCycles = (ackCycle == 0) ? TO : ackCycle;
      for (int c = 1; c <= waitCycles; c++) begin
        busAck   = (ackCycle != 0) && (c == ackCycle);
        busRdata = busAck ? rdata : $urandom;
        setExp(1'b1, 1'b1, 1'b0, 1'b0);
        nextCycle();
      end
      if (!rw[1]) modelLoad = (ackCycle == 0) ? 32'hDEADBEEF : rdata;
      busAck   = 1'($urandom_range(0, 1));
      busRdata = $urandom;
      setExp(1'b0, 1'b0, 1'b0, ackCycle == 0);
      nextCycle();
    end
  endtask

  initial begin
    logic [1:0]    rw;
    logic [AW-1:0] addr;
    rst        = 1'b1;
    memrw      = 2'b01;
    memaddr    = 32'h100;
    memdata    = 32'h0;
    busAck     = 1'b0;
    busRdata   = 32'h0;
    modelWe    = 1'b0;
    modelAddr  = '0;
    modelWdata = '0;
    modelLoad  = '0;
    carryErr   = 1'b0;
    setExp(1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("reset stall_req", stallReq, 1'b0);
    checkOutput("reset bus_req", busReq, 1'b0);
    checkOutput("reset load_data", loadData, 32'h0);
    checkOutput("reset bus_addr", busAddr, 32'h0);
    @(negedge clk);
    rst   = 1'b0;
    memrw = 2'b00;
    nextCycle();
    checkEn = 1;

    $display("[TB] read 0x100, ack in cycle 2");
    applyStimulus(2'b01, 32'h100, 32'h0, 2, 32'h12345678);
    checkOutput("read load literal", loadData, 32'h12345678);

    $display("[TB] write 0x200, ack in cycle 1");
    applyStimulus(2'b10, 32'h200, 32'hCAFEF00D, 1, 32'h0BADF00D);
    checkOutput("write we literal", busWe, 1'b1);
    checkOutput("write addr literal", busAddr, 32'h200);
    checkOutput("write wdata literal", busWdata, 32'hCAFEF00D);
    checkOutput("write keeps load", loadData, 32'h12345678);

    $display("[TB] misaligned read 0x102");
    applyStimulus(2'b01, 32'h102, 32'h0, 1, 32'h0);
    checkOutput("misaligned addr_err literal", addrErr, 1'b1);
    checkOutput("misaligned no bus_req", busReq, 1'b0);
    applyStimulus(2'b00, 32'h104, 32'h0, 1, 32'h0);

    $display("[TB] back-to-back read then write");
    applyStimulus(2'b01, 32'h300, 32'h0, 3, 32'hA5A5A5A5);
    applyStimulus(2'b10, 32'h304, 32'h5A5A5A5A, 1, 32'h0);
    applyStimulus(2'b11, 32'h308, 32'h0, 1, 32'h0);

    $display("[TB] reset during WAIT");
    checkEn = 0;
    memrw   = 2'b01;
    memaddr = 32'h400;
    busAck  = 1'b0;
    nextCycle();
    nextCycle();
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset bus_req", busReq, 1'b0);
    checkOutput("async reset stall_req", stallReq, 1'b0);
    checkOutput("async reset load_data", loadData, 32'h0);
    checkOutput("async reset bus_addr", busAddr, 32'h0);
    busAck = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    memrw = 2'b00;
    nextCycle();
    busAck = 1'b0;
    checkOutput("stray ack bus_req", busReq, 1'b0);
    checkOutput("stray ack load_data", loadData, 32'h0);
    checkOutput("stray ack stall_req", stallReq, 1'b0);
    modelWe    = 1'b0;
    modelAddr  = '0;
    modelWdata = '0;
    modelLoad  = '0;
    carryErr   = 1'b0;
    checkEn    = 1;

    $display("[TB] random accesses");
    for (int i = 0; i < 60; i++) begin
      rw   = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      applyStimulus(rw, addr, $urandom, $urandom_range(1, TO), $urandom);
    end

`ifdef MEM_BUS_TIMEOUT_EN
    $display("[TB] read with no ack");
    applyStimulus(2'b01, 32'h500, 32'h0, 0, 32'h0);
    checkOutput("timeout load literal", loadData, 32'hDEADBEEF);
    applyStimulus(2'b10, 32'h504, 32'h11112222, 0, 32'h0);
`endif

    applyStimulus(2'b00, 32'h0, 32'h0, 1, 32'h0);
    checkEn = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
